// File: rtl/fracnet_mac_dsp48_pipe.sv
// Pipelined unsigned x signed multiply-accumulate with tag shift register,
// clock-enable stall and saturating or wrapping running accumulator.
module fracnet_mac_dsp48_pipe #(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 12,
    parameter int NUM_STAGE = 3,
    parameter int ACC_WIDTH = 32,
    parameter int SATURATE  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic [A_WIDTH-1:0]   din0,
    input  logic [B_WIDTH-1:0]   din1,
    input  logic                 acc_en,
    input  logic                 acc_first,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] dout,
    output logic                 ovf
);
    localparam int PW = A_WIDTH + B_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [A_WIDTH-1:0]   a_q, a_d;
    logic [B_WIDTH-1:0]   b_q, b_d;
    logic [NUM_STAGE-1:0] vld_q, vld_d;
    logic [NUM_STAGE-1:0] acc_en_q, acc_en_d;
    logic [NUM_STAGE-1:0] first_q, first_d;

    logic signed [PW-1:0] a_ext, b_ext, prod_c, prod_last;

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0]        dout_q, dout_d;
    logic                        out_valid_q, out_valid_d;
    logic                        ovf_q, ovf_d;
    logic signed [ACC_WIDTH-1:0] p_ext;
    logic [ACC_WIDTH:0]          sum;
    logic                        sum_ovf;

    // Operand register and tag shift register; ce=0 freezes everything.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        vld_d    = vld_q;
        acc_en_d = acc_en_q;
        first_d  = first_q;
        if (ce) begin
            a_d         = din0;
            b_d         = din1;
            vld_d[0]    = in_valid;
            acc_en_d[0] = acc_en;
            first_d[0]  = acc_first;
            for (int k = 1; k < NUM_STAGE; k++) begin
                vld_d[k]    = vld_q[k-1];
                acc_en_d[k] = acc_en_q[k-1];
                first_d[k]  = first_q[k-1];
            end
        end
    end

    assign a_ext  = PW'($signed({1'b0, a_q}));
    assign b_ext  = PW'($signed(b_q));
    assign prod_c = a_ext * b_ext;

    generate
        if (NUM_STAGE > 1) begin : g_pipe
            logic signed [PW-1:0] prod_q [NUM_STAGE-1];
            logic signed [PW-1:0] prod_d [NUM_STAGE-1];

            always_comb begin
                for (int k = 0; k < NUM_STAGE-1; k++) prod_d[k] = prod_q[k];
                if (ce) begin
                    prod_d[0] = prod_c;
                    for (int k = 1; k < NUM_STAGE-1; k++) prod_d[k] = prod_q[k-1];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < NUM_STAGE-1; k++) prod_q[k] <= '0;
                end else begin
                    for (int k = 0; k < NUM_STAGE-1; k++) prod_q[k] <= prod_d[k];
                end
            end

            assign prod_last = prod_q[NUM_STAGE-2];
        end else begin : g_nopipe
            assign prod_last = prod_c;
        end
    endgenerate

    assign p_ext   = ACC_WIDTH'(prod_last);
    assign sum     = {acc_q[ACC_WIDTH-1], acc_q} + {p_ext[ACC_WIDTH-1], p_ext};
    assign sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];

    always_comb begin
        acc_d       = acc_q;
        dout_d      = dout_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        if (ce) begin
            out_valid_d = vld_q[NUM_STAGE-1];
            if (vld_q[NUM_STAGE-1]) begin
                if (!acc_en_q[NUM_STAGE-1]) begin
                    dout_d = p_ext;
                end else if (first_q[NUM_STAGE-1]) begin
                    acc_d  = p_ext;
                    dout_d = p_ext;
                    ovf_d  = 1'b0;
                end else begin
                    acc_d = sum[ACC_WIDTH-1:0];
                    if (sum_ovf) begin
                        ovf_d = 1'b1;
                        // Sign of the wide sum tells which rail was crossed.
                        if (SATURATE != 0) acc_d = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
                    end
                    dout_d = acc_d;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q         <= '0;
            b_q         <= '0;
            vld_q       <= '0;
            acc_en_q    <= '0;
            first_q     <= '0;
            acc_q       <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            vld_q       <= vld_d;
            acc_en_q    <= acc_en_d;
            first_q     <= first_d;
            acc_q       <= acc_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_fracnet_mac_dsp48_pipe.sv
// Scoreboard bench: a default 32-bit instance plus 20-bit saturating and
// 20-bit wrapping instances, all driven by the same stimulus.
module tb_fracnet_mac_dsp48_pipe;
    localparam int NS = 3;

    logic        clk = 1'b0;
    logic        reset, ce, in_valid, acc_en, acc_first;
    logic [7:0]  din0;
    logic [11:0] din1;

    logic        ov0, ov1, ov2;
    logic        f0, f1, f2;
    logic [31:0] d0;
    logic [19:0] d1, d2;

    always #5 clk = ~clk;

    fracnet_mac_dsp48_pipe u_dut (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_en(acc_en), .acc_first(acc_first), .out_valid(ov0), .dout(d0), .ovf(f0)
    );

    fracnet_mac_dsp48_pipe #(.ACC_WIDTH(20), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_en(acc_en), .acc_first(acc_first), .out_valid(ov1), .dout(d1), .ovf(f1)
    );

    fracnet_mac_dsp48_pipe #(.ACC_WIDTH(20), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .din0(din0), .din1(din1),
        .acc_en(acc_en), .acc_first(acc_first), .out_valid(ov2), .dout(d2), .ovf(f2)
    );

    typedef struct {
        int     due;
        longint d0, d1, d2;
        logic   f0, f1, f2;
    } exp_t;

    exp_t   sb_q[$];
    int     n_checks = 0;
    int     n_errors = 0;
    int     cnt = 0;
    int     acc_w [3] = '{32, 20, 20};
    bit     sat   [3] = '{1'b1, 1'b1, 1'b0};
    longint m_acc [3];
    logic   m_ovf [3];
    longint m_dout[3];

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint sx(input longint v, input int w);
        logic [63:0] t;
        t = v;
        t = t << (64 - w);
        return $signed(t) >>> (64 - w);
    endfunction

    function automatic longint dut_dout(input int i);
        case (i)
            0:       return longint'($signed(d0));
            1:       return longint'($signed(d1));
            default: return longint'($signed(d2));
        endcase
    endfunction

    function automatic logic dut_ov(input int i);
        case (i)
            0:       return ov0;
            1:       return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic logic dut_ovf(input int i);
        case (i)
            0:       return f0;
            1:       return f1;
            default: return f2;
        endcase
    endfunction

    task automatic model_push();
        exp_t   e;
        longint p, s, mx, mn;
        p = longint'(din0) * longint'($signed(din1));
        for (int i = 0; i < 3; i++) begin
            mx = (longint'(1) <<< (acc_w[i] - 1)) - 1;
            mn = -(longint'(1) <<< (acc_w[i] - 1));
            if (!acc_en) begin
                m_dout[i] = p;
            end else if (acc_first) begin
                m_acc[i]  = p;
                m_dout[i] = p;
                m_ovf[i]  = 1'b0;
            end else begin
                s = m_acc[i] + p;
                if (s > mx || s < mn) begin
                    m_ovf[i] = 1'b1;
                    m_acc[i] = sat[i] ? ((s > mx) ? mx : mn) : sx(s, acc_w[i]);
                end else begin
                    m_acc[i] = s;
                end
                m_dout[i] = m_acc[i];
            end
        end
        e.due = cnt + NS;
        e.d0 = m_dout[0]; e.d1 = m_dout[1]; e.d2 = m_dout[2];
        e.f0 = m_ovf[0];  e.f1 = m_ovf[1];  e.f2 = m_ovf[2];
        sb_q.push_back(e);
    endtask

    task automatic cycle();
        logic   prev_ov [3];
        longint prev_d  [3];
        logic   was_rst, was_ce, exp_ov;
        exp_t   e;
        longint ed [3];
        logic   ef [3];
        for (int i = 0; i < 3; i++) begin
            prev_ov[i] = dut_ov(i);
            prev_d[i]  = dut_dout(i);
        end
        @(posedge clk);
        was_rst = reset;
        was_ce  = ce;
        if (was_rst) begin
            sb_q.delete();
            for (int i = 0; i < 3; i++) begin
                m_acc[i] = 0; m_ovf[i] = 1'b0; m_dout[i] = 0;
            end
        end else if (was_ce) begin
            cnt++;
            if (in_valid) model_push();
        end
        #1;
        if (was_rst) begin
            for (int i = 0; i < 3; i++) begin
                check_eq($sformatf("rst_valid%0d", i), longint'(dut_ov(i)), 0);
                check_eq($sformatf("rst_dout%0d", i), dut_dout(i), 0);
                check_eq($sformatf("rst_ovf%0d", i), longint'(dut_ovf(i)), 0);
            end
        end else if (!was_ce) begin
            for (int i = 0; i < 3; i++) begin
                check_eq($sformatf("stall_valid%0d", i), longint'(dut_ov(i)), longint'(prev_ov[i]));
                check_eq($sformatf("stall_dout%0d", i), dut_dout(i), prev_d[i]);
            end
        end else begin
            exp_ov = (sb_q.size() > 0) && (sb_q[0].due == cnt);
            for (int i = 0; i < 3; i++)
                check_eq($sformatf("out_valid%0d@%0d", i, cnt), longint'(dut_ov(i)), longint'(exp_ov));
            if (exp_ov) begin
                e = sb_q.pop_front();
                ed[0] = e.d0; ed[1] = e.d1; ed[2] = e.d2;
                ef[0] = e.f0; ef[1] = e.f1; ef[2] = e.f2;
                for (int i = 0; i < 3; i++) begin
                    check_eq($sformatf("dout%0d@%0d", i, cnt), dut_dout(i), ed[i]);
                    check_eq($sformatf("ovf%0d@%0d", i, cnt), longint'(dut_ovf(i)), longint'(ef[i]));
                end
            end
        end
    endtask

    task automatic drive(input logic v, input int a, input int b, input logic en, input logic first);
        logic [31:0] bv;
        bv        = b;
        in_valid  = v;
        din0      = a[7:0];
        din1      = bv[11:0];
        acc_en    = en;
        acc_first = first;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; ce = 1'b1; in_valid = 1'b0; acc_en = 1'b0; acc_first = 1'b0;
        din0 = '0; din1 = '0;
        for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0; m_ovf[i] = 1'b0; m_dout[i] = 0;
        end
        idle(2);
        reset = 1'b0;
        idle(2);

        // pass-through, extreme product then zero
        drive(1, 255, -2048, 0, 0);
        drive(1, 0, 2047, 0, 0);
        idle(5);

        // accumulate then restart
        drive(1, 3, 5, 1, 1);
        drive(1, 2, -4, 1, 0);
        drive(1, 10, 1, 1, 0);
        drive(1, 1, 1, 1, 1);
        idle(5);

        // stall mid-stream: junk presented while ce=0 must not be captured
        drive(1, 5, 7, 1, 1);
        drive(1, 6, -3, 1, 0);
        ce = 1'b0;
        drive(1, 99, 99, 1, 1);
        drive(1, 99, 99, 1, 1);
        drive(1, 99, 99, 1, 1);
        ce = 1'b1;
        drive(1, 7, 100, 1, 0);
        drive(1, 200, -2000, 0, 0);
        idle(1);
        ce = 1'b0;
        idle(3);
        ce = 1'b1;
        idle(5);

        // saturation / wrap on the 20-bit instances
        drive(1, 255, 2047, 1, 1);
        drive(1, 255, 2047, 1, 0);
        drive(1, 255, 2047, 1, 0);
        drive(1, 255, 2047, 1, 0);
        drive(1, 1, 2, 1, 1);
        idle(5);

        // bubbles between accumulating samples
        drive(1, 4, 4, 1, 1);
        drive(0, 50, 50, 1, 0);
        drive(1, 3, -1, 1, 0);
        drive(1, 2, 9, 1, 0);
        drive(0, 77, 77, 1, 1);
        idle(5);

        // reset with samples in flight, ovf set beforehand
        drive(1, 255, 2047, 1, 1);
        drive(1, 255, 2047, 1, 0);
        idle(4);
        drive(1, 9, 9, 1, 1);
        drive(1, 9, 9, 1, 0);
        drive(1, 9, 9, 1, 0);
        reset = 1'b1;
        drive(1, 11, 11, 1, 1);
        reset = 1'b0;
        drive(1, 3, -7, 1, 0);
        idle(6);

        check_eq("drain", longint'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
